// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
package boot_pkg;
  localparam int unsigned BOOT_WORD_W          = 32;
  localparam int unsigned BOOT_BYTES_PER_WORD  = 4;
  localparam int unsigned BOOT_TIMEOUT_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_ERR  = 2'd3
  } boot_state_t;
endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembler with an inter-byte idle timeout.
module word_assembler
  import boot_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = BOOT_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   word_valid_c,
  output logic [BOOT_WORD_W-1:0] word_c
);
  localparam int unsigned IW = $clog2(BOOT_BYTES_PER_WORD);
  localparam int unsigned GW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(BOOT_BYTES_PER_WORD - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);

  logic [BOOT_WORD_W-9:0] asm_q;
  logic [IW-1:0]          byte_idx_q;
  logic [GW-1:0]          gap_q;
  logic                   accept_c;

  assign accept_c     = en && rx_valid && !flush;
  assign word_valid_c = accept_c && (byte_idx_q == LAST_IDX);
  // The final byte bypasses the holding register so the word is usable this cycle.
  assign word_c       = {rx_data, asm_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q      <= '0;
      byte_idx_q <= '0;
      gap_q      <= '0;
    end else if (flush) begin
      byte_idx_q <= '0;
      gap_q      <= '0;
    end else if (accept_c) begin
      case (byte_idx_q)
        IW'(0):  asm_q[7:0]   <= rx_data;
        IW'(1):  asm_q[15:8]  <= rx_data;
        IW'(2):  asm_q[23:16] <= rx_data;
        default: ;
      endcase
      byte_idx_q <= byte_idx_q + IW'(1);
      gap_q      <= '0;
    end else if (en && (byte_idx_q != '0)) begin
      // Expiry drops the partial word; a byte arriving this cycle wins instead.
      if (gap_q == GAP_LAST) begin
        byte_idx_q <= '0;
        gap_q      <= '0;
      end else begin
        gap_q <= gap_q + GW'(1);
      end
    end else begin
      gap_q <= '0;
    end
  end
endmodule

// File: rtl/cpu_boot_loader.sv
// Loads a length-prefixed UART image into instruction memory, then releases CPU reset.
module cpu_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned AW             = 12,
  parameter int unsigned TIMEOUT_CYCLES = BOOT_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic                   reload,
  output logic                   imem_we,
  output logic [AW-1:0]          imem_addr,
  output logic [BOOT_WORD_W-1:0] imem_wdata,
  output logic                   cpu_reset,
  output logic                   loading,
  output logic                   load_error,
  output logic [AW:0]            words_loaded
);
  localparam int unsigned LW   = BOOT_WORD_W + 1;
  localparam int unsigned LENW = AW + 1;
  localparam logic [LW-1:0] MAX_LEN = LW'(1) << AW;

  boot_state_t            state_q, state_d;
  logic [AW:0]            len_q, len_d;
  logic                   imem_we_d, cpu_reset_d, loading_d, load_error_d;
  logic [AW-1:0]          imem_addr_d;
  logic [BOOT_WORD_W-1:0] imem_wdata_d;
  logic [AW:0]            words_d;
  logic                   asm_en_c;
  logic                   word_valid_c;
  logic [BOOT_WORD_W-1:0] word_c;

  assign asm_en_c = (state_q == S_LEN) || (state_q == S_LOAD);

  word_assembler #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_asm (
    .clk         (clk),
    .rst_n       (reset_n),
    .en          (asm_en_c),
    .flush       (reload),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .word_valid_c(word_valid_c),
    .word_c      (word_c)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_LEN;
      len_q        <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_reset    <= 1'b1;
      loading      <= 1'b1;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      imem_we      <= imem_we_d;
      imem_addr    <= imem_addr_d;
      imem_wdata   <= imem_wdata_d;
      cpu_reset    <= cpu_reset_d;
      loading      <= loading_d;
      load_error   <= load_error_d;
      words_loaded <= words_d;
    end
  end

  // Next state; run is entered the cycle after the final write pulse.
  always_comb begin
    state_d = state_q;
    if (reload) begin
      state_d = S_LEN;
    end else begin
      case (state_q)
        S_LEN: begin
          if (word_valid_c) begin
            if (word_c == '0)                 state_d = S_RUN;
            else if ({1'b0, word_c} > MAX_LEN) state_d = S_ERR;
            else                              state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          if (imem_we && (words_loaded == len_q)) state_d = S_RUN;
        end
        default: ;
      endcase
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    words_d      = words_loaded;
    len_d        = len_q;
    cpu_reset_d  = (state_d != S_RUN);
    loading_d    = (state_d == S_LEN) || (state_d == S_LOAD);
    load_error_d = (state_d == S_ERR);
    if (reload) begin
      words_d = '0;
    end else if (word_valid_c && (state_q == S_LEN)) begin
      len_d   = LENW'(word_c);
      words_d = '0;
    end else if (word_valid_c && (state_q == S_LOAD)) begin
      imem_we_d    = 1'b1;
      imem_addr_d  = words_loaded[AW-1:0];
      imem_wdata_d = word_c;
      words_d      = words_loaded + LENW'(1);
    end
  end
endmodule

// File: tb/tb_cpu_boot_loader.sv
// Self-checking bench for cpu_boot_loader (AW=4, TIMEOUT_CYCLES=50).
module tb_cpu_boot_loader;
  localparam int unsigned AW = 4;
  localparam int unsigned TO = 50;

  logic          clk;
  logic          reset_n;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          reload;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          loading;
  logic          load_error;
  logic [AW:0]   words_loaded;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [31:0] len;
    int          n_send;
    int          n_wr;
    logic [31:0] seed;
    logic        cpu_reset;
    logic        loading;
    logic        load_error;
    logic [AW:0] wl;
  } vec_t;
  vec_t vecs[7];

  cpu_boot_loader #(.AW(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .reload      (reload),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_reset   (cpu_reset),
    .loading     (loading),
    .load_error  (load_error),
    .words_loaded(words_loaded)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
    chk("reload_loading", 32'(loading), 32'd1);
    chk("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("reload_error", 32'(load_error), 32'd0);
    chk("reload_words", 32'(words_loaded), 32'd0);
  endtask

  // Write scoreboard: each write pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset_n && imem_we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%08h expected no write",
                 imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e.addr));
        chk("wr_data", imem_wdata, e.data);
      end
    end
  end

  initial begin
    vecs[0] = '{len:32'd2,          n_send:2,  n_wr:2,  seed:32'h1000_0001, cpu_reset:1'b0, loading:1'b0, load_error:1'b0, wl:5'd2};
    vecs[1] = '{len:32'd16,         n_send:16, n_wr:16, seed:32'hA5A5_0000, cpu_reset:1'b0, loading:1'b0, load_error:1'b0, wl:5'd16};
    vecs[2] = '{len:32'd17,         n_send:3,  n_wr:0,  seed:32'h0000_0005, cpu_reset:1'b1, loading:1'b0, load_error:1'b1, wl:5'd0};
    vecs[3] = '{len:32'h8000_0000,  n_send:1,  n_wr:0,  seed:32'h0BAD_0BAD, cpu_reset:1'b1, loading:1'b0, load_error:1'b1, wl:5'd0};
    vecs[4] = '{len:32'd3,          n_send:2,  n_wr:2,  seed:32'h3333_0000, cpu_reset:1'b1, loading:1'b1, load_error:1'b0, wl:5'd2};
    vecs[5] = '{len:32'd0,          n_send:1,  n_wr:0,  seed:32'h7777_7777, cpu_reset:1'b0, loading:1'b0, load_error:1'b0, wl:5'd0};
    vecs[6] = '{len:32'd1,          n_send:3,  n_wr:1,  seed:32'hC0DE_0001, cpu_reset:1'b0, loading:1'b0, load_error:1'b0, wl:5'd1};

    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    reload   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_loading", 32'(loading), 32'd1);
    chk("rst_error", 32'(load_error), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);

    // Nominal two-word load with cycle-exact release.
    send_word(32'd2);
    chk("nom_len_loading", 32'(loading), 32'd1);
    expect_wr(4'd0, 32'h0010_0513);
    send_word(32'h0010_0513);
    chk("nom_we0", 32'(imem_we), 32'd1);
    expect_wr(4'd1, 32'h0000_006F);
    send_word(32'h0000_006F);
    chk("nom_we1", 32'(imem_we), 32'd1);
    chk("nom_cpu_reset_t1", 32'(cpu_reset), 32'd1);
    step();
    chk("nom_we_drop", 32'(imem_we), 32'd0);
    chk("nom_cpu_reset_t2", 32'(cpu_reset), 32'd0);
    chk("nom_loading", 32'(loading), 32'd0);
    chk("nom_words", 32'(words_loaded), 32'd2);

    // Zero length goes straight to run.
    do_reload();
    send_word(32'd0);
    chk("zero_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("zero_loading", 32'(loading), 32'd0);

    // Oversize length latches the error; reload clears it.
    do_reload();
    send_word(32'd17);
    chk("big_error", 32'(load_error), 32'd1);
    chk("big_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("big_loading", 32'(loading), 32'd0);
    send_word(32'h1234_5678);
    idle(2);
    chk("big_words", 32'(words_loaded), 32'd0);
    chk("big_error_held", 32'(load_error), 32'd1);
    do_reload();

    // Timeout discards a partial length.
    send_byte(8'h01);
    send_byte(8'h00);
    idle(60);
    send_word(32'd1);
    expect_wr(4'd0, 32'hDEAD_BEEF);
    send_word(32'hDEAD_BEEF);
    step();
    chk("to_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("to_words", 32'(words_loaded), 32'd1);

    // A byte arriving on the expiry cycle is kept.
    do_reload();
    send_byte(8'h01);
    idle(TO - 1);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("to49_loading", 32'(loading), 32'd1);
    expect_wr(4'd0, 32'h1234_5678);
    send_word(32'h1234_5678);
    step();
    chk("to49_cpu_reset", 32'(cpu_reset), 32'd0);

    // One more idle cycle expires the partial word.
    do_reload();
    send_byte(8'h02);
    idle(TO);
    send_word(32'd1);
    expect_wr(4'd0, 32'h4433_2211);
    send_word(32'h4433_2211);
    step();
    chk("to50_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("to50_words", 32'(words_loaded), 32'd1);

    // Reload mid-load, colliding with a byte that must be dropped.
    do_reload();
    send_word(32'd3);
    expect_wr(4'd0, 32'hDDCC_BBAA);
    send_word(32'hDDCC_BBAA);
    idle(1);
    chk("mid_words_before", 32'(words_loaded), 32'd1);
    reload   = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h04;
    step();
    reload   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    chk("mid_loading", 32'(loading), 32'd1);
    chk("mid_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid_words", 32'(words_loaded), 32'd0);
    send_word(32'd1);
    expect_wr(4'd0, 32'hCAFE_F00D);
    send_word(32'hCAFE_F00D);
    step();
    chk("mid_reload_cpu_reset", 32'(cpu_reset), 32'd0);

    // Table-driven sessions.
    for (int v = 0; v < 7; v++) begin
      do_reload();
      send_word(vecs[v].len);
      for (int i = 0; i < vecs[v].n_send; i++) begin
        logic [31:0] w;
        w = vecs[v].seed + 32'(i) * 32'h0102_0304;
        if (i < vecs[v].n_wr) expect_wr(AW'(i), w);
        send_word(w);
      end
      idle(3);
      chk("tbl_cpu_reset", 32'(cpu_reset), 32'(vecs[v].cpu_reset));
      chk("tbl_loading", 32'(loading), 32'(vecs[v].loading));
      chk("tbl_error", 32'(load_error), 32'(vecs[v].load_error));
      chk("tbl_words", 32'(words_loaded), 32'(vecs[v].wl));
    end

    // Asynchronous reset from run, sampled before any clock edge.
    chk("arst_pre_cpu_reset", 32'(cpu_reset), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("arst_loading", 32'(loading), 32'd1);
    chk("arst_words", 32'(words_loaded), 32'd0);
    chk("arst_wdata", imem_wdata, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    chk("post_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("post_loading", 32'(loading), 32'd1);
    chk("post_error", 32'(load_error), 32'd0);
    chk("post_we", 32'(imem_we), 32'd0);
    chk("post_addr", 32'(imem_addr), 32'd0);

    idle(2);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_boot_loader.md
Name: cpu_boot_loader

Overview:
- Receives a program image as a UART byte stream and writes it into CPU instruction memory.
- Holds the CPU in reset until the load completes, then releases it.
- Sits between the UART receiver, the instruction-memory write port and the reset input of cpu_top.
- A reload pulse, from a synchronized and debounced button, returns the CPU to reset and re-arms loading.

Parameters:
- AW, 12: instruction-memory word-address width; capacity is 2**AW words.
- TIMEOUT_CYCLES, 1000000: maximum idle gap between bytes of one word before the partial word is discarded (10 ms at 100 MHz).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle strobe, rx_data valid; no back-pressure
- rx_data  in  8  received byte
- reload  in  1  one-cycle pulse: abort or finish the current session and start a new load
- imem_we  out  1  instruction-memory write enable, one-cycle pulse
- imem_addr  out  AW  word address of the write
- imem_wdata  out  32  write data
- cpu_reset  out  1  active-high reset to cpu_top
- loading  out  1  high in S_LEN and S_LOAD
- load_error  out  1  sticky length error
- words_loaded  out  AW+1  words written in the current session

Behaviour:
- All outputs are registered.
- Reset values:
  - state=S_LEN, cpu_reset=1, loading=1, load_error=0.
  - imem_we=0, imem_addr=0, imem_wdata=0, words_loaded=0.
  - byte_idx=0, gap counter=0.
- Byte assembly:
  - Little-endian: byte k (0..3) lands in bits [8k+7:8k].
  - byte_idx increments on each accepted byte and wraps 3->0 on word completion.
- States:
  - S_LEN: first 4 bytes form len.
    - len==0 -> S_RUN.
    - len > 2**AW -> S_ERR, load_error=1.
    - Otherwise -> S_LOAD with words_loaded=0.
  - S_LOAD: on the 4th byte of a word at cycle t:
    - t+1: imem_we=1 for exactly one cycle, imem_addr=words_loaded[AW-1:0], imem_wdata=word, words_loaded increments.
    - If the write is word len, then at t+2: state=S_RUN, cpu_reset=0, loading=0.
  - S_RUN: cpu_reset=0; rx bytes ignored; imem_we stays 0.
  - S_ERR: cpu_reset=1, load_error=1, loading=0; rx bytes ignored.
- reload, in any state:
  - Next cycle: state=S_LEN, cpu_reset=1, loading=1, load_error=0, byte_idx=0, words_loaded=0.
  - Memory contents already written are left untouched.
- Timeout:
  - In S_LEN or S_LOAD with byte_idx!=0, the gap counter increments every cycle without rx_valid.
  - When it reaches TIMEOUT_CYCLES: byte_idx=0 and the partial word is dropped. State and words_loaded are unchanged, so in S_LEN the length is re-collected from scratch.
  - The counter clears on every accepted byte and whenever byte_idx==0.
- Simultaneous events:
  - reload with rx_valid: reload wins and the byte is dropped.
  - rx_valid in the same cycle the timeout expires: the byte is accepted and the timeout does not fire.
  - rx_valid in the cycle of an imem_we pulse: accepted normally, since assembly uses a separate register from imem_wdata.
- Address wrap is impossible: len is capped at 2**AW, so imem_addr never exceeds 2**AW-1.
- Asynchronous reset mid-load forces the reset values immediately and cpu_reset asserts without waiting for a clock edge. A partially loaded image remains in memory.

Decomposition:
- Package boot_pkg:
  - boot_state_t enum {S_LEN, S_LOAD, S_RUN, S_ERR}.
  - BOOT_WORD_W=32, BOOT_BYTES_PER_WORD=4, BOOT_TIMEOUT_DEFAULT=1000000.
- Sub-module word_assembler:
  - Does the byte shift-in, byte_idx, gap counter and timeout.
  - Outputs word_valid (one-cycle) and word.
  - Has a flush input, driven by reload.
- cpu_boot_loader keeps the FSM, length check, counters and output registers.

Test Plan:
- Nominal load: send bytes 02 00 00 00, 13 05 10 00, 6F 00 00 00 -> writes addr0=0x00100513 and addr1=0x0000006F (one-cycle imem_we each); cpu_reset falls 2 cycles after the last byte; words_loaded=2.
- Zero length: send 00 00 00 00 -> S_RUN with no imem_we; cpu_reset=0 one cycle after the 4th byte.
- Oversize, with AW=4: send 11 00 00 00 (len=17) -> load_error=1, cpu_reset stays 1, later bytes ignored; a reload pulse clears load_error and loading=1.
- Timeout, with TIMEOUT_CYCLES=50: send 01 00, idle 60 cycles, then 01 00 00 00 EF BE AD DE -> single write of 0xDEADBEEF at addr0.
- Reload mid-load: len=3, one word written, then reload pulse together with an rx_valid byte -> byte dropped, state=S_LEN, words_loaded=0, cpu_reset=1; the next full load succeeds.
- Async reset: assert reset_n=0 while in S_RUN -> cpu_reset=1 immediately without a clock edge; after release, loading=1 and all outputs are at reset values.
